// File: rtl/param_updown_counter.sv
// Parameterised up/down counter with saturate-or-wrap bounds and a wrap pulse.
// Optional reload-on-underflow: define PARAM_UPDOWN_COUNTER_AUTORELOAD_EN.
module param_updown_counter #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             latch,
  input  logic             inc,
  input  logic             dec,
  input  logic             sat,
  input  logic [WIDTH-1:0] IN,
  output logic [WIDTH-1:0] count,
  output logic             zero_flag,
  output logic             max_flag,
  output logic             wrap_pulse
);

  localparam logic [WIDTH-1:0] MAX  = '1;
  localparam logic [WIDTH-1:0] ZERO = '0;
  localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);

  logic             up;
  logic             dn;
  logic             at_max;
  logic             at_zero;
  logic [WIDTH-1:0] uflow_target;
  logic [WIDTH-1:0] count_nxt;
  logic             wrap_nxt;

  // Simultaneous inc and dec cancel out.
  assign up      = inc & ~dec;
  assign dn      = dec & ~inc;
  assign at_max  = (count == MAX);
  assign at_zero = (count == ZERO);

`ifdef PARAM_UPDOWN_COUNTER_AUTORELOAD_EN
  logic [WIDTH-1:0] reload;

  // Reload value follows every latch so underflow restarts the period.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      reload <= ZERO;
    end else if (latch) begin
      reload <= IN;
    end
  end

  assign uflow_target = reload;
`else
  assign uflow_target = MAX;
`endif

  // Next-state selection: latch beats counting, counting beats hold.
  always_comb begin
    count_nxt = count;
    wrap_nxt  = 1'b0;
    if (latch) begin
      count_nxt = IN;
    end else if (up) begin
      if (!at_max) begin
        count_nxt = count + ONE;
      end else if (!sat) begin
        count_nxt = ZERO;
        wrap_nxt  = 1'b1;
      end
    end else if (dn) begin
      if (!at_zero) begin
        count_nxt = count - ONE;
      end else if (!sat) begin
        count_nxt = uflow_target;
        wrap_nxt  = 1'b1;
      end
    end
  end

  // Counter and wrap pulse registers; reset clears any pending pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count      <= ZERO;
      wrap_pulse <= 1'b0;
    end else begin
      count      <= count_nxt;
      wrap_pulse <= wrap_nxt;
    end
  end

  // Flags look only at the registered count.
  assign zero_flag = at_zero;
  assign max_flag  = at_max;

endmodule

// File: tb/tb_param_updown_counter.sv
// Scoreboard bench for param_updown_counter (WIDTH=4).
// Integer reference model; monitor compares on falling edges.
module tb_param_updown_counter;

  localparam int W    = 4;
  localparam int MAXV = (1 << W) - 1;

  typedef struct {
    int c;
    int w;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst;
  logic         latch;
  logic         inc;
  logic         dec;
  logic         sat;
  logic [W-1:0] IN;
  logic [W-1:0] count;
  logic         zero_flag;
  logic         max_flag;
  logic         wrap_pulse;

  int   checks = 0;
  int   errors = 0;
  exp_t q[$];
  int   mcount = 0;
  int   mreload = 0;

  param_updown_counter #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .latch     (latch),
    .inc       (inc),
    .dec       (dec),
    .sat       (sat),
    .IN        (IN),
    .count     (count),
    .zero_flag (zero_flag),
    .max_flag  (max_flag),
    .wrap_pulse(wrap_pulse)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk_state(input string nm, input int c, input int w);
    chk({nm, ".count"}, int'(count), c);
    chk({nm, ".zero"}, int'(zero_flag), (c == 0) ? 1 : 0);
    chk({nm, ".max"}, int'(max_flag), (c == MAXV) ? 1 : 0);
    chk({nm, ".wrap"}, int'(wrap_pulse), w);
  endtask

  // Drive one cycle of inputs, predict the result, queue it after the edge.
  task automatic step(input logic l, input logic i, input logic d,
                      input logic s, input int v);
    int n;
    int w;
    int tgt;
    latch = l;
    inc   = i;
    dec   = d;
    sat   = s;
    IN    = W'(v);
    n = mcount;
    w = 0;
    if (rst) begin
      n = 0;
    end else if (l) begin
      n = v;
      mreload = v;
    end else if (i != d) begin
      n = mcount + (i ? 1 : -1);
`ifdef PARAM_UPDOWN_COUNTER_AUTORELOAD_EN
      tgt = mreload;
`else
      tgt = MAXV;
`endif
      if (n < 0 || n > MAXV) begin
        if (s) begin
          n = mcount;
        end else begin
          n = (n < 0) ? tgt : 0;
          w = 1;
        end
      end
    end
    @(posedge clk);
    mcount = n;
    q.push_back('{n, w});
    #1;
  endtask

  task automatic async_reset(input string nm);
    @(negedge clk);
    #1;
    rst = 1'b1;
    #1;
    mcount  = 0;
    mreload = 0;
    chk_state(nm, 0, 0);
  endtask

  // Monitor: every falling edge, retire one prediction.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk_state("sb", e.c, e.w);
      end
    end
  end

  initial begin
    rst = 1'b1; latch = 0; inc = 0; dec = 0; sat = 0; IN = '0;
    #1;
    chk_state("reset0", 0, 0);
    step(1, 1, 0, 0, 9);
    step(1, 0, 1, 0, 5);
    rst = 1'b0;

    // count to 7 then asynchronous reset
    step(1, 0, 0, 0, 6);
    step(0, 1, 0, 1, 0);
    async_reset("rst_mid7");
    step(1, 1, 0, 0, 3);
    rst = 1'b0;

    // saturating down from 3
    step(1, 0, 0, 1, 3);
    repeat (5) step(0, 0, 1, 1, 0);

    // wrapping up from 14
    step(1, 0, 0, 0, 14);
    repeat (3) step(0, 1, 0, 0, 0);

    // wrapping down from 1 (or reload period)
    step(1, 0, 0, 0, 1);
    repeat (3) step(0, 0, 1, 0, 0);
    step(1, 0, 0, 0, 2);
    repeat (7) step(0, 0, 1, 0, 0);

    // latch beats inc+dec, then inc+dec holds
    step(1, 1, 1, 0, 9);
    repeat (3) step(0, 1, 1, 0, 0);

    // saturate at max, then wrap with pulse, then reset drops pulse
    step(1, 0, 0, 1, 15);
    step(0, 1, 0, 1, 0);
    step(0, 1, 0, 0, 0);
    async_reset("rst_wrap");
    step(0, 1, 0, 0, 0);
    rst = 1'b0;

    // back-to-back wraps at zero/max
    step(1, 0, 0, 0, 0);
    step(0, 0, 1, 0, 0);
    step(0, 1, 0, 0, 0);
    step(0, 0, 1, 0, 0);

    // randomized traffic
    for (int k = 0; k < 500; k++) begin
      if ($urandom_range(0, 99) == 0) begin
        async_reset("rst_rand");
        step(0, 1'($urandom), 1'($urandom), 1'($urandom), 0);
        rst = 1'b0;
      end
      step($urandom_range(0, 9) == 0, 1'($urandom), 1'($urandom),
           1'($urandom), int'($urandom_range(0, MAXV)));
    end

    latch = 0; inc = 0; dec = 0;
    for (int k = 0; k < 4 && q.size() > 0; k++) @(negedge clk);
    #1;
    chk("drain", q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
